hqm_aw_residue_cnt_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one residue-protected update datapath among NUM_REQ requesters.
- Each requester owns a saturating counter protected by a 2-bit mod-3 residue.
- The block grants one increment/decrement per cycle, runs it through a 2-stage read/check/update pipeline built on the residue adder, and flags residue mismatches.
- Sits beside credit/occupancy counters in HQM units that need parity-class protection on arithmetic state.

---
 rtl/hqm_aw_residue_cnt_arb.sv | 187 ++++++++++++++++++
 tb/tb_hqm_aw_residue_cnt_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_aw_residue_cnt_arb.sv
// Round-robin shared update path for NUM_REQ mod-3 residue protected saturating counters.
// Optional HQM_AW_RESIDUE_CNT_INJ_EN adds a stored-residue error injection port.
module hqm_aw_residue_cnt_arb #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  parameter int DELTA_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_v,
  input  logic [NUM_REQ-1:0]         req_dec,
  input  logic [NUM_REQ*DELTA_W-1:0] req_delta,
`ifdef HQM_AW_RESIDUE_CNT_INJ_EN
  input  logic                       inj_v,
  input  logic [2:0]                 inj_idx,
`endif
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       done_v,
  output logic [2:0]                 done_idx,
  output logic                       ovf,
  output logic                       unf,
  output logic                       err,
  output logic [NUM_REQ*CNT_W-1:0]   cnt,
  output logic [NUM_REQ*2-1:0]       cnt_res
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [1:0] mod3(input logic [CNT_W-1:0] v);
    logic [2:0] t;
    logic [1:0] r;
    r = '0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      t = {r, v[i]};
      r = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    end
    return r;
  endfunction

  function automatic logic [1:0] res_add(input logic [1:0] a,
                                         input logic [1:0] b);
    logic [2:0] t;
    t = {1'b0, a} + {1'b0, b};
    return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
  endfunction

  localparam logic [1:0] MAX_RES = mod3({CNT_W{1'b1}});

  logic [NUM_REQ-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0][1:0]         res_q, res_d;
  logic [NUM_REQ-1:0][DELTA_W-1:0] delta_a;
  logic [IW-1:0]                   ptr_q, ptr_d;
  logic                            s1_v_q, s1_v_d;
  logic [IW-1:0]                   s1_idx_q, s1_idx_d;
  logic                            s1_dec_q, s1_dec_d;
  logic [DELTA_W-1:0]              s1_delta_q, s1_delta_d;
  logic                            done_v_q, done_v_d;
  logic [2:0]                      done_idx_q, done_idx_d;
  logic                            ovf_q, ovf_d;
  logic                            unf_q, unf_d;
  logic                            err_q, err_d;

  logic [NUM_REQ-1:0] busy, elig, gnt_w;
  logic [IW-1:0]      gnt_idx;
  logic               found;
  int                 j;

  logic [CNT_W-1:0] c, dext;
  logic [1:0]       r, rc, rd;
  logic [CNT_W:0]   s;
  logic             chk_fail;

  assign delta_a = req_delta;

  // A requester with an op in stage 1 is masked to avoid read-after-write.
  always_comb begin
    busy  = s1_v_q ? (NUM_REQ'(1) << s1_idx_q) : '0;
    elig  = req_v & ~busy;
    found = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && elig[j]) begin
        found   = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    gnt_w = (found && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  assign gnt = gnt_w;

  always_comb begin
    c    = cnt_q[s1_idx_q];
    r    = res_q[s1_idx_q];
    dext = CNT_W'(s1_delta_q);
    rc   = mod3(c);
    rd   = mod3(dext);
    chk_fail = (rc != r) || (r == 2'd3);
    if (s1_dec_q) s = {1'b0, c} - {1'b0, dext};
    else          s = {1'b0, c} + {1'b0, dext};
  end

  always_comb begin
    cnt_d      = cnt_q;
    res_d      = res_q;
    ptr_d      = ptr_q;
    done_v_d   = 1'b0;
    done_idx_d = done_idx_q;
    ovf_d      = 1'b0;
    unf_d      = 1'b0;
    err_d      = 1'b0;
    s1_v_d     = |gnt_w;
    s1_idx_d   = gnt_idx;
    s1_dec_d   = req_dec[gnt_idx];
    s1_delta_d = delta_a[gnt_idx];
    if (|gnt_w)
      ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
`ifdef HQM_AW_RESIDUE_CNT_INJ_EN
    for (int i = 0; i < NUM_REQ; i++)
      if (inj_v && inj_idx == 3'(i))
        res_d[i] = res_q[i] ^ 2'b01;
`endif
    // Commit is applied last so it overrides a same-index injection.
    if (s1_v_q) begin
      done_v_d   = 1'b1;
      done_idx_d = 3'(s1_idx_q);
      if (chk_fail) begin
        err_d = 1'b1;
        cnt_d[s1_idx_q] = c;
        res_d[s1_idx_q] = r;
      end else if (!s1_dec_q && s[CNT_W]) begin
        ovf_d = 1'b1;
        cnt_d[s1_idx_q] = '1;
        res_d[s1_idx_q] = MAX_RES;
      end else if (s1_dec_q && s[CNT_W]) begin
        unf_d = 1'b1;
        cnt_d[s1_idx_q] = '0;
        res_d[s1_idx_q] = '0;
      end else begin
        cnt_d[s1_idx_q] = s[CNT_W-1:0];
        res_d[s1_idx_q] = s1_dec_q ? res_add(r, {rd[0], rd[1]})
                                   : res_add(r, rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      res_q      <= '0;
      ptr_q      <= '0;
      s1_v_q     <= 1'b0;
      s1_idx_q   <= '0;
      s1_dec_q   <= 1'b0;
      s1_delta_q <= '0;
      done_v_q   <= 1'b0;
      done_idx_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      ptr_q      <= ptr_d;
      s1_v_q     <= s1_v_d;
      s1_idx_q   <= s1_idx_d;
      s1_dec_q   <= s1_dec_d;
      s1_delta_q <= s1_delta_d;
      done_v_q   <= done_v_d;
      done_idx_q <= done_idx_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      err_q      <= err_d;
    end
  end

  assign done_v   = done_v_q;
  assign done_idx = done_idx_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign err      = err_q;
  assign cnt      = cnt_q;
  assign cnt_res  = res_q;

endmodule

// File: tb/tb_hqm_aw_residue_cnt_arb.sv
// Directed bench for hqm_aw_residue_cnt_arb (default 4 x 16-bit, delta 4).
// Injection vectors run only when HQM_AW_RESIDUE_CNT_INJ_EN is defined.
module tb_hqm_aw_residue_cnt_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_v;
  logic [3:0]  req_dec;
  logic [15:0] req_delta;
`ifdef HQM_AW_RESIDUE_CNT_INJ_EN
  logic        inj_v;
  logic [2:0]  inj_idx;
`endif
  logic [3:0]  gnt;
  logic        done_v;
  logic [2:0]  done_idx;
  logic        ovf;
  logic        unf;
  logic        err;
  logic [63:0] cnt;
  logic [7:0]  cnt_res;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hqm_aw_residue_cnt_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_v     (req_v),
    .req_dec   (req_dec),
    .req_delta (req_delta),
`ifdef HQM_AW_RESIDUE_CNT_INJ_EN
    .inj_v     (inj_v),
    .inj_idx   (inj_idx),
`endif
    .gnt       (gnt),
    .done_v    (done_v),
    .done_idx  (done_idx),
    .ovf       (ovf),
    .unf       (unf),
    .err       (err),
    .cnt       (cnt),
    .cnt_res   (cnt_res)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return 32'(cnt[i*16 +: 16]);
  endfunction

  function automatic logic [31:0] res_of(input int i);
    return 32'(cnt_res[i*2 +: 2]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_v     = '0;
    req_dec   = '0;
    req_delta = '0;
`ifdef HQM_AW_RESIDUE_CNT_INJ_EN
    inj_v   = 1'b0;
    inj_idx = '0;
`endif
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Single request; returns in the cycle its done_v is visible.
  task automatic do_op(input int idx, input logic dec,
                       input logic [3:0] d);
    req_v                  = '0;
    req_v[idx]             = 1'b1;
    req_dec[idx]           = dec;
    req_delta[idx*4 +: 4]  = d;
    tick;
    req_v = '0;
    tick;
    #1;
  endtask

  initial begin
    int rem[4];

    // reset state
    do_reset;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done_v), 0);
    chk("rst_cnt", cnt[31:0] | cnt[63:32], 0);
    chk("rst_res", 32'(cnt_res), 0);
    chk("rst_flags", 32'({ovf, unf, err, done_idx}), 0);

    // 1: single increment, latency 2
    req_v           = 4'b0001;
    req_dec         = '0;
    req_delta[3:0]  = 4'd5;
    #1;
    chk("t1_gnt", 32'(gnt), 32'h1);
    tick;
    req_v = '0;
    #1;
    chk("t1_done_early", 32'(done_v), 0);
    tick;
    #1;
    chk("t1_done", 32'(done_v), 1);
    chk("t1_idx", 32'(done_idx), 0);
    chk("t1_cnt0", cnt_of(0), 5);
    chk("t1_res0", res_of(0), 2);
    chk("t1_err", 32'(err), 0);
    tick;
    #1;
    chk("t1_done_pulse", 32'(done_v), 0);

    // 2: round robin over all four
    do_reset;
    rem = '{2, 2, 2, 2};
    req_dec   = '0;
    req_delta = 16'h1111;
    for (int cyc = 0; cyc < 8; cyc++) begin
      for (int i = 0; i < 4; i++) req_v[i] = (rem[i] > 0);
      #1;
      chk("t2_gnt", 32'(gnt), 32'(1) << (cyc % 4));
      rem[cyc % 4]--;
      tick;
    end
    req_v = '0;
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("t2_cnt", cnt_of(i), 2);
      chk("t2_res", res_of(i), 2);
    end

    // 3: single requester, every other cycle
    do_reset;
    req_v           = 4'b0100;
    req_delta[11:8] = 4'd3;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      chk("t3_gnt", 32'(gnt), (cyc % 2 == 0) ? 32'h4 : 32'h0);
      tick;
    end
    req_v = '0;
    tick;
    tick;
    chk("t3_cnt2", cnt_of(2), 9);
    chk("t3_res2", res_of(2), 0);

    // 4: saturation and clamp
    do_reset;
    for (int n = 0; n < 4369; n++) do_op(1, 1'b0, 4'd15);
    chk("t4_cnt_max", cnt_of(1), 32'hFFFF);
    chk("t4_res_max", res_of(1), 0);
    chk("t4_no_ovf", 32'(ovf), 0);
    do_op(1, 1'b1, 4'd1);
    chk("t4_cnt_fffe", cnt_of(1), 32'hFFFE);
    chk("t4_res_fffe", res_of(1), 2);
    do_op(1, 1'b0, 4'd4);
    chk("t4_ovf", 32'(ovf), 1);
    chk("t4_ovf_idx", 32'(done_idx), 1);
    chk("t4_ovf_cnt", cnt_of(1), 32'hFFFF);
    chk("t4_ovf_res", res_of(1), 0);
    do_op(0, 1'b0, 4'd3);
    chk("t4_cnt3", cnt_of(0), 3);
    do_op(0, 1'b1, 4'd15);
    chk("t4_unf", 32'(unf), 1);
    chk("t4_unf_ovf", 32'(ovf), 0);
    chk("t4_unf_cnt", cnt_of(0), 0);
    chk("t4_unf_res", res_of(0), 0);

`ifdef HQM_AW_RESIDUE_CNT_INJ_EN
    // 5: injected residue fault
    do_reset;
    do_op(3, 1'b0, 4'd7);
    chk("t5_cnt3", cnt_of(3), 7);
    chk("t5_res3", res_of(3), 1);
    inj_v   = 1'b1;
    inj_idx = 3'd3;
    tick;
    inj_v = 1'b0;
    #1;
    chk("t5_inj_res", res_of(3), 0);
    do_op(3, 1'b0, 4'd1);
    chk("t5_err", 32'(err), 1);
    chk("t5_err_idx", 32'(done_idx), 3);
    chk("t5_err_cnt", cnt_of(3), 7);
    chk("t5_err_res", res_of(3), 0);
`endif

    // 6: reset mid-flight
    do_reset;
    req_v     = 4'b1111;
    req_dec   = '0;
    req_delta = 16'h1111;
    #1;
    chk("t6_gnt0", 32'(gnt), 32'h1);
    tick;
    #1;
    chk("t6_gnt1", 32'(gnt), 32'h2);
    tick;
    rst = 1'b1;
    #1;
    chk("t6_gnt_rst", 32'(gnt), 0);
    chk("t6_cnt0_pre", cnt_of(0), 1);
    tick;
    rst = 1'b0;
    #1;
    chk("t6_done_drop", 32'(done_v), 0);
    chk("t6_cnt_clr", cnt[31:0] | cnt[63:32], 0);
    chk("t6_gnt_post", 32'(gnt), 32'h1);
    tick;
    #1;
    chk("t6_done_none", 32'(done_v), 0);
    chk("t6_cnt1", cnt_of(1), 0);
    req_v = '0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
